seg_scan_driver: RTL and testbench

- Downstream stage of the code-box controller.
- Consumes the two 9-bit segment patterns (num_led1 = right digit, num_led2 = left digit) and a blink request, and time-multiplexes them onto one shared segment bus with per-digit select.
- Inserts dead-time between digits to suppress ghosting, snapshots each pattern at slot start to prevent tearing, and optionally blinks the display on the error/lockout indication.

---
 rtl/seg_scan_driver_if.sv | 45 ++++
 rtl/seg_scan_driver.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Signal bundle between the code-box controller and the
//               multiplexed seven-segment scan driver.
//                 seg_in1    [8:0] right-digit pattern (a-g, dp, bit8 unused)
//                 seg_in2    [8:0] left-digit pattern, same encoding
//                 blank            force all segments dark
//                 blink_req        request blinking of the whole display
//                 seg_out    [7:0] shared segment bus
//                 dig_sel    [1:0] active-low digit select (bit0 = right)
//                 frame_tick       one-cycle pulse at end of each scan frame
//               master = pattern source, slave = scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if;
    logic [8:0] seg_in1;
    logic [8:0] seg_in2;
    logic       blank;
    logic       blink_req;
    logic [7:0] seg_out;
    logic [1:0] dig_sel;
    logic       frame_tick;

    modport master (
        output seg_in1,
        output seg_in2,
        output blank,
        output blink_req,
        input  seg_out,
        input  dig_sel,
        input  frame_tick
    );

    modport slave (
        input  seg_in1,
        input  seg_in2,
        input  blank,
        input  blink_req,
        output seg_out,
        output dig_sel,
        output frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexes two digit patterns onto one shared segment
//               bus. Scan order DEAD1 -> DIG1 -> DEAD2 -> DIG2, with all
//               digits dark during the DEAD slots to suppress ghosting. Each
//               pattern is snapshotted when its slot is entered so a slot
//               never shows a torn pattern. Outputs are registered.
// Ports       : clk             system clock
//               rst             asynchronous reset, active-high
//               bus (slave)     seg_in1/seg_in2/blank/blink_req in,
//                               seg_out/dig_sel/frame_tick out
// Parameters  : SCAN_DIV        cycles per digit slot (>=1)
//               DEAD_CYC        cycles of dead time before each slot (0 = none)
//               BLINK_DIV       cycles per blink half-period (>=1)
//               COMMON_ANODE    1 = seg_out active-low
// Macro       : SEG_BLINK_EN    builds the blink counter/phase logic; when
//                               undefined blink_req is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV     = 12000,
    parameter int DEAD_CYC     = 200,
    parameter int BLINK_DIV    = 6000000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_driver_if.slave bus
);

    // Slot counter is shared by DEAD and DIG slots, so it is sized for the
    // longer of the two.
    localparam int c_SLOT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
    localparam int c_CNT_W    = (c_SLOT_MAX > 1) ? $clog2(c_SLOT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEAD_LAST = c_CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    localparam logic [7:0] c_SEG_OFF = COMMON_ANODE ? 8'hFF : 8'h00;

    localparam logic [1:0] c_ST_DEAD1 = 2'd0;
    localparam logic [1:0] c_ST_DIG1  = 2'd1;
    localparam logic [1:0] c_ST_DEAD2 = 2'd2;
    localparam logic [1:0] c_ST_DIG2  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_slot_end;

    logic [7:0]         r_snap1;
    logic [7:0]         r_snap2;
    logic [7:0]         w_seg_pat;
    logic [7:0]         w_seg_drive;
    logic               w_in_dig;
    logic               w_dark;

    logic [7:0]         r_seg_out;
    logic [1:0]         r_dig_sel;
    logic               r_frame_tick;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_DEAD1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // With DEAD_CYC = 0 the DEAD slots end immediately; only the reset
    // state DEAD1 is ever occupied, for a single cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_end  = 1'b0;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        case (r_state)
            c_ST_DEAD1: begin
                w_slot_end = (DEAD_CYC == 0) || (r_cnt == c_DEAD_LAST);
                if (w_slot_end) w_state_nxt = c_ST_DIG1;
            end
            c_ST_DIG1: begin
                w_slot_end = (r_cnt == c_SCAN_LAST);
                if (w_slot_end) w_state_nxt = (DEAD_CYC == 0) ? c_ST_DIG2 : c_ST_DEAD2;
            end
            c_ST_DEAD2: begin
                w_slot_end = (DEAD_CYC == 0) || (r_cnt == c_DEAD_LAST);
                if (w_slot_end) w_state_nxt = c_ST_DIG2;
            end
            default: begin
                w_slot_end = (r_cnt == c_SCAN_LAST);
                if (w_slot_end) w_state_nxt = (DEAD_CYC == 0) ? c_ST_DIG1 : c_ST_DEAD1;
            end
        endcase
        if (w_slot_end) w_cnt_nxt = '0;
    end

    // ------------------------------------------------------------------
    // Pattern snapshot on slot entry (bit8 of each input is not displayed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap1 <= 8'h00;
            r_snap2 <= 8'h00;
        end else begin
            if (w_slot_end && (w_state_nxt == c_ST_DIG1)) r_snap1 <= bus.seg_in1[7:0];
            if (w_slot_end && (w_state_nxt == c_ST_DIG2)) r_snap2 <= bus.seg_in2[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Dark control (blank / blink)
    // ------------------------------------------------------------------
`ifdef SEG_BLINK_EN
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic                 r_blink_req_d;

    // A fresh request restarts the counter in the visible phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blink_req_d <= 1'b0;
        end else begin
            r_blink_req_d <= bus.blink_req;
            if (!bus.blink_req || !r_blink_req_d) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
            end else if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + c_BLINK_W'(1);
            end
        end
    end

    assign w_dark = bus.blank | (bus.blink_req & r_blink_phase);

    logic w_unused_bits;
    assign w_unused_bits = bus.seg_in1[8] ^ bus.seg_in2[8];
`else
    assign w_dark = bus.blank;

    // Blink request and divider are kept for pin/parameter compatibility.
    logic w_unused_bits;
    assign w_unused_bits = bus.seg_in1[8] ^ bus.seg_in2[8] ^ bus.blink_req ^ (BLINK_DIV > 0);
`endif

    // ------------------------------------------------------------------
    // Output polarity
    // ------------------------------------------------------------------
    assign w_in_dig  = (r_state == c_ST_DIG1) || (r_state == c_ST_DIG2);
    assign w_seg_pat = (r_state == c_ST_DIG1) ? r_snap1 : r_snap2;

    generate
        if (COMMON_ANODE) begin : g_active_low
            assign w_seg_drive = ~w_seg_pat;
        end else begin : g_active_high
            assign w_seg_drive = w_seg_pat;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered outputs: driven from the pre-edge state, so they trail
    // the FSM by one cycle. Digit select stays active while dark.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_out    <= c_SEG_OFF;
            r_dig_sel    <= 2'b11;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg_out    <= (w_in_dig && !w_dark) ? w_seg_drive : c_SEG_OFF;
            r_dig_sel    <= (r_state == c_ST_DIG1) ? 2'b10 :
                            (r_state == c_ST_DIG2) ? 2'b01 : 2'b11;
            r_frame_tick <= (r_state == c_ST_DIG2) && w_slot_end;
        end
    end

    assign bus.seg_out    = r_seg_out;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver. Two instances
//               (active-high and active-low segments) share one stimulus.
//               A frame-position model predicts every output each cycle;
//               literal checks pin the model at hand-computed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int c_SCAN  = 4;
    localparam int c_DEAD  = 2;
    localparam int c_BLINK = 8;
    localparam int c_FRAME = 2 * (c_DEAD + c_SCAN);

    logic clk;
    logic rst;

    seg_scan_driver_if bus0 ();
    seg_scan_driver_if bus1 ();

    assign bus1.seg_in1   = bus0.seg_in1;
    assign bus1.seg_in2   = bus0.seg_in2;
    assign bus1.blank     = bus0.blank;
    assign bus1.blink_req = bus0.blink_req;

    seg_scan_driver #(
        .SCAN_DIV     (c_SCAN),
        .DEAD_CYC     (c_DEAD),
        .BLINK_DIV    (c_BLINK),
        .COMMON_ANODE (1'b0)
    ) u_dut_cc (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seg_scan_driver #(
        .SCAN_DIV     (c_SCAN),
        .DEAD_CYC     (c_DEAD),
        .BLINK_DIV    (c_BLINK),
        .COMMON_ANODE (1'b1)
    ) u_dut_ca (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: position within the frame (t = edges since reset release)
    // decides slot; blink phase follows from cycles since request rise.
    // ------------------------------------------------------------------
    int         t;
    int         k;
    logic       prev_req;
    logic [7:0] m_snap1, m_snap2;
    logic [7:0] exp_seg;
    logic [1:0] exp_dig;
    logic       exp_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t        <= 0;
            k        <= 0;
            prev_req <= 1'b0;
            m_snap1  <= 8'h00;
            m_snap2  <= 8'h00;
            exp_seg  <= 8'h00;
            exp_dig  <= 2'b11;
            exp_tick <= 1'b0;
        end else begin : model_step
            int   p;
            logic in1, in2, dark, ph;
            p   = t % c_FRAME;
            in1 = (p >= c_DEAD) && (p < c_DEAD + c_SCAN);
            in2 = (p >= 2 * c_DEAD + c_SCAN);
            ph  = ((k / c_BLINK) % 2) == 1;
`ifdef SEG_BLINK_EN
            dark = bus0.blank | (bus0.blink_req & ph);
`else
            dark = bus0.blank | (1'b0 & ph);
`endif
            exp_dig  <= in1 ? 2'b10 : (in2 ? 2'b01 : 2'b11);
            exp_seg  <= dark ? 8'h00 : (in1 ? m_snap1 : (in2 ? m_snap2 : 8'h00));
            exp_tick <= (p == c_FRAME - 1);
            if ((t + 1) % c_FRAME == c_DEAD)              m_snap1 <= bus0.seg_in1[7:0];
            if ((t + 1) % c_FRAME == 2 * c_DEAD + c_SCAN) m_snap2 <= bus0.seg_in2[7:0];
            if (!bus0.blink_req || !prev_req) k <= 0;
            else                              k <= k + 1;
            prev_req <= bus0.blink_req;
            t        <= t + 1;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("seg_out_cc",    {24'd0, bus0.seg_out},    {24'd0, exp_seg});
        chk("dig_sel_cc",    {30'd0, bus0.dig_sel},    {30'd0, exp_dig});
        chk("frame_tick_cc", {31'd0, bus0.frame_tick}, {31'd0, exp_tick});
        chk("seg_out_ca",    {24'd0, bus1.seg_out},    {24'd0, ~exp_seg});
        chk("dig_sel_ca",    {30'd0, bus1.dig_sel},    {30'd0, exp_dig});
        chk("frame_tick_ca", {31'd0, bus1.frame_tick}, {31'd0, exp_tick});
    end

    // Advance to the negedge following edge number 'target'.
    task automatic wait_t(input int target);
        int n;
        n = 0;
        while (t < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (t < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_t: reached t=%0d, required t=%0d", t, target);
        end
    endtask

    initial begin : stim
        int n;
        rst            = 1'b1;
        bus0.seg_in1   = 9'h006;
        bus0.seg_in2   = 9'h05b;
        bus0.blank     = 1'b0;
        bus0.blink_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_seg_cc", {24'd0, bus0.seg_out}, 32'h00);
        chk("rst_seg_ca", {24'd0, bus1.seg_out}, 32'hFF);
        chk("rst_dig",    {30'd0, bus0.dig_sel}, 32'h3);
        chk("rst_tick",   {31'd0, bus0.frame_tick}, 32'h0);
        rst = 1'b0;

        // Basic frame
        wait_t(3);  chk("lit_dig_dig1", {30'd0, bus0.dig_sel}, 32'h2);
                    chk("lit_seg_dig1", {24'd0, bus0.seg_out}, 32'h06);
        wait_t(9);  chk("lit_dig_dig2", {30'd0, bus0.dig_sel}, 32'h1);
                    chk("lit_seg_dig2", {24'd0, bus0.seg_out}, 32'h5b);
        wait_t(12); chk("lit_tick_on",  {31'd0, bus0.frame_tick}, 32'h1);
        wait_t(13); chk("lit_tick_off", {31'd0, bus0.frame_tick}, 32'h0);

        // Mid-slot pattern change does not tear the slot
        wait_t(27); bus0.seg_in1 = 9'h06d;
        wait_t(30); chk("lit_snap_hold", {24'd0, bus0.seg_out}, 32'h06);
        wait_t(39); chk("lit_snap_new",  {24'd0, bus0.seg_out}, 32'h6d);

        // Blank during DIG2
        wait_t(56); bus0.blank = 1'b1;
        wait_t(57); chk("lit_blank_seg", {24'd0, bus0.seg_out}, 32'h00);
                    chk("lit_blank_dig", {30'd0, bus0.dig_sel}, 32'h1);
        wait_t(59); bus0.blank = 1'b0;
        wait_t(60); chk("lit_blank_end", {24'd0, bus0.seg_out}, 32'h5b);

        // Blink: rise, hold, drop, rise again
        wait_t(72); bus0.blink_req = 1'b1;
        wait_t(81); chk("lit_blink_vis", {24'd0, bus0.seg_out}, 32'h5b);
`ifdef SEG_BLINK_EN
        wait_t(82); chk("lit_blink_dark", {24'd0, bus0.seg_out}, 32'h00);
`else
        wait_t(82); chk("lit_blink_off",  {24'd0, bus0.seg_out}, 32'h5b);
`endif
        wait_t(120); bus0.blink_req = 1'b0;
        wait_t(124); bus0.blink_req = 1'b1;
        wait_t(150); bus0.blink_req = 1'b0;
                     bus0.seg_in1   = 9'h13f;

        // Active-low polarity
        wait_t(157); chk("lit_ca_dead", {24'd0, bus1.seg_out}, 32'hFF);
        wait_t(159); chk("lit_ca_dig1", {24'd0, bus1.seg_out}, 32'hC0);
                     chk("lit_cc_dig1", {24'd0, bus0.seg_out}, 32'h3f);

        // Asynchronous reset in the middle of DIG2
        wait_t(165);
        chk("lit_pre_rst_dig", {30'd0, bus0.dig_sel}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_seg_cc", {24'd0, bus0.seg_out}, 32'h00);
        chk("lit_arst_seg_ca", {24'd0, bus1.seg_out}, 32'hFF);
        chk("lit_arst_dig",    {30'd0, bus0.dig_sel}, 32'h3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus0.dig_sel == 2'b10) break;
        end
        chk("lit_restart_lat", n, c_DEAD + 1);

        wait_t(30);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
